// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle RV32I load/store unit. It sits between the CPU datapath and a
// variable-latency data memory port. LB/LH/LW/LBU/LHU/SB/SH/SW requests
// become word-aligned memory transactions with byte strobes. Load data is
// returned sign- or zero-extended through a one-cycle response pulse.
// Misaligned and illegal accesses are answered directly, without a memory
// transaction.
//
// Optional feature (compile-time macro LSU_TIMEOUT_EN):
//   When defined, a WAIT-state watchdog aborts the access after TIMEOUT
//   cycles without mem_ack_i and reports fault 11. When undefined, WAIT
//   lasts until mem_ack_i arrives and fault 11 is never produced.
//
// Parameters:
//   ADDR_W   byte address width
//   TIMEOUT  WAIT cycles without ack before abort (LSU_TIMEOUT_EN only)
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   req_valid_i   CPU presents an access
//   req_ready_o   LSU can accept (IDLE only)
//   req_write_i   1 = store, 0 = load
//   req_funct3_i  RV32I funct3
//   req_addr_i    byte address
//   req_wdata_i   store data (rs2)
//   mem_req_o     registered memory request, held until mem_ack_i
//   mem_we_o      memory write enable
//   mem_addr_o    word address (byte address with [1:0] cleared)
//   mem_wdata_o   lane-replicated store data
//   mem_wstrb_o   byte-lane strobes, 0 for loads
//   mem_ack_i     memory completion, mem_rdata_i valid in the same cycle
//   mem_rdata_i   memory read word
//   resp_valid_o  one-cycle response pulse
//   resp_rdata_o  extended load data, 0 for stores and faults
//   resp_fault_o  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
//   busy_o        high in any state other than IDLE
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic [1:0]        resp_fault_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;

`ifdef LSU_TIMEOUT_EN
    localparam logic [1:0] FAULT_TIMEOUT = 2'b11;
    // At least 8 bits, wider only if TIMEOUT needs it.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q;
`endif

    state_t            state_q;
    logic [2:0]        funct3_q;
    logic [1:0]        addrLo_q;
    logic              memReq_q;
    logic              memWe_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [31:0]       memWdata_q;
    logic [3:0]        memWstrb_q;
    logic              respValid_q;
    logic [31:0]       respRdata_q;
    logic [1:0]        respFault_q;

    logic              reqIllegal;
    logic              reqMisaligned;
    logic [31:0]       storeData;
    logic [3:0]        storeStrb;
    logic [31:0]       loadShifted;
    logic [31:0]       loadData;

    // Request decode, evaluated on the live request while IDLE.
    // funct3[1:0] encodes the access size (0 byte, 1 half, 2 word) for both
    // loads and stores, so lane placement and alignment only look at those
    // bits; legality is checked separately over the full funct3.
    always_comb begin
        reqIllegal    = 1'b0;
        reqMisaligned = 1'b0;
        storeData     = req_wdata_i;
        storeStrb     = 4'b1111;

        if (req_write_i) begin
            reqIllegal = (req_funct3_i > 3'd2);
        end else begin
            reqIllegal = !(req_funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end

        case (req_funct3_i[1:0])
            2'd1:    reqMisaligned = req_addr_i[0];
            2'd2:    reqMisaligned = (req_addr_i[1:0] != 2'b00);
            default: reqMisaligned = 1'b0;
        endcase

        case (req_funct3_i[1:0])
            2'd0: begin
                storeData = {4{req_wdata_i[7:0]}};
                storeStrb = 4'b0001 << req_addr_i[1:0];
            end
            2'd1: begin
                storeData = {2{req_wdata_i[15:0]}};
                storeStrb = req_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                storeData = req_wdata_i;
                storeStrb = 4'b1111;
            end
        endcase
    end

    // Load extraction from the word on the memory bus. The latched address
    // offset moves the addressed byte/half down to bit 0; a legal half is
    // always half-aligned, so the same byte shift serves both sizes.
    always_comb begin
        loadShifted = mem_rdata_i >> {addrLo_q, 3'b000};
        case (funct3_q)
            3'd0:    loadData = {{24{loadShifted[7]}}, loadShifted[7:0]};
            3'd1:    loadData = {{16{loadShifted[15]}}, loadShifted[15:0]};
            3'd4:    loadData = {24'd0, loadShifted[7:0]};
            3'd5:    loadData = {16'd0, loadShifted[15:0]};
            default: loadData = mem_rdata_i;
        endcase
    end

    // Control FSM with registered outputs. The response registers are
    // cleared every cycle by default, so resp_valid is a single-cycle pulse
    // and resp_rdata/resp_fault read as zero outside it. The memory-side
    // fields are loaded once on accept and then left untouched, which keeps
    // them stable for the whole WAIT period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            funct3_q    <= 3'd0;
            addrLo_q    <= 2'd0;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= 32'd0;
            memWstrb_q  <= 4'd0;
            respValid_q <= 1'b0;
            respRdata_q <= 32'd0;
            respFault_q <= FAULT_OK;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            respValid_q <= 1'b0;
            respRdata_q <= 32'd0;
            respFault_q <= FAULT_OK;

            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        funct3_q <= req_funct3_i;
                        addrLo_q <= req_addr_i[1:0];
                        if (reqIllegal) begin
                            state_q     <= DONE;
                            respValid_q <= 1'b1;
                            respFault_q <= FAULT_ILLEGAL;
                        end else if (reqMisaligned) begin
                            state_q     <= DONE;
                            respValid_q <= 1'b1;
                            respFault_q <= FAULT_MISALIGN;
                        end else begin
                            state_q    <= WAIT;
                            memReq_q   <= 1'b1;
                            memWe_q    <= req_write_i;
                            memAddr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                            memWdata_q <= req_write_i ? storeData : 32'd0;
                            memWstrb_q <= req_write_i ? storeStrb : 4'd0;
`ifdef LSU_TIMEOUT_EN
                            cnt_q      <= '0;
`endif
                        end
                    end
                end

                WAIT: begin
                    // An ack in the cycle that would otherwise time out still
                    // completes normally, so it is tested first.
                    if (mem_ack_i) begin
                        state_q     <= DONE;
                        memReq_q    <= 1'b0;
                        respValid_q <= 1'b1;
                        respRdata_q <= memWe_q ? 32'd0 : loadData;
                        respFault_q <= FAULT_OK;
`ifdef LSU_TIMEOUT_EN
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q     <= DONE;
                        memReq_q    <= 1'b0;
                        respValid_q <= 1'b1;
                        respFault_q <= FAULT_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
`endif
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q  <= IDLE;
                    memReq_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign mem_req_o    = memReq_q;
    assign mem_we_o     = memWe_q;
    assign mem_addr_o   = memAddr_q;
    assign mem_wdata_o  = memWdata_q;
    assign mem_wstrb_o  = memWstrb_q;
    assign resp_valid_o = respValid_q;
    assign resp_rdata_o = respRdata_q;
    assign resp_fault_o = respFault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. A driver issues directed and
// random requests and pushes the expected memory transaction and expected
// response into queues; a memory responder and a response monitor pop and
// compare independently. With LSU_TIMEOUT_EN defined the watchdog cases
// are exercised as well (the DUT is built with TIMEOUT = 4).
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  fault;
        bit          memPath;
        bit          timeout;
        time         acceptTime;
    } expResp_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        time         acceptTime;
    } memTxn_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic        busy;

    expResp_t expQ[$];
    memTxn_t  memQ[$];
    int       errors = 0;
    int       checks = 0;
    bit       respOn = 0;
    time      lastAckTime = 0;

    load_store_unit #(
        .ADDR_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_funct3_i(req_funct3),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_wstrb_o (mem_wstrb),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .resp_valid_o(resp_valid),
        .resp_rdata_o(resp_rdata),
        .resp_fault_o(resp_fault),
        .busy_o      (busy)
    );

    // 10-time-unit clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got 0x%0h, want 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Reference behaviour written from the ISA rules: access size in bytes,
    // byte offset within the word, arithmetic sign extension, lane
    // replication by multiplication.
    function automatic void model(input bit w, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdIn,
                                  input logic [31:0] rdIn,
                                  output logic [1:0] fault, output logic [31:0] resp,
                                  output logic [31:0] wd, output logic [3:0] strb);
        int unsigned off  = addr % 4;
        int unsigned size = 1 << f3[1:0];
        bit legal;
        longint field;
        longint lane;
        legal = w ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (!legal)                fault = 2'b10;
        else if (addr % size != 0) fault = 2'b01;
        else                       fault = 2'b00;

        field = longint'(rdIn >> (off * 8));
        if (size < 4) field = field % (longint'(1) << (size * 8));
        if (f3 < 4 && size < 4 && field >= (longint'(1) << (size * 8 - 1)))
            field = field - (longint'(1) << (size * 8));
        resp = (w || fault != 2'b00) ? 32'd0 : field[31:0];

        lane = longint'(wdIn);
        if (size < 4) lane = lane % (longint'(1) << (size * 8));
        lane = lane * ((size == 1) ? 64'h01010101 : (size == 2) ? 64'h00010001 : 64'h1);
        wd   = lane[31:0];
        strb = 4'(((1 << size) - 1) << off);
    endfunction

    // Drive one request at a falling edge, keep it presented until the DUT
    // accepts it on a rising edge, then queue what should come back.
    task automatic applyStimulus(input bit w, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rd, input int delay);
        expResp_t e;
        memTxn_t  m;
        int       n;
        logic [1:0]  fault;
        logic [31:0] resp;
        logic [31:0] mwd;
        logic [3:0]  strb;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) begin
            checkOutput("accept_bound", {63'd0, req_ready}, 64'd1);
            return;
        end
        model(w, f3, addr, wd, rd, fault, resp, mwd, strb);
        e.memPath    = (fault == 2'b00);
        e.timeout    = e.memPath && (delay < 0);
        e.fault      = e.timeout ? 2'b11 : fault;
        e.rdata      = e.timeout ? 32'd0 : resp;
        e.acceptTime = $time;
        if (e.memPath) begin
            m.addr       = addr & ~32'd3;
            m.we         = w;
            m.wstrb      = w ? strb : 4'd0;
            m.wdata      = w ? mwd : 32'd0;
            m.rdata      = rd;
            m.delay      = delay;
            m.acceptTime = $time;
            memQ.push_back(m);
        end
        expQ.push_back(e);
    endtask

    task automatic checkMemFields(input memTxn_t m);
        checkOutput("mem_req",   {63'd0, mem_req}, 64'd1);
        checkOutput("mem_addr",  {32'd0, mem_addr}, {32'd0, m.addr});
        checkOutput("mem_we",    {63'd0, mem_we}, {63'd0, m.we});
        checkOutput("mem_wstrb", {60'd0, mem_wstrb}, {60'd0, m.wstrb});
        checkOutput("mem_wdata", {32'd0, mem_wdata}, {32'd0, m.wdata});
    endtask

    // Memory responder: acks each queued transaction after its delay and
    // checks the request fields every cycle of the wait. Stray acks are
    // sprinkled in while no request is pending; the DUT must ignore them.
    initial begin
        memTxn_t m;
        int k;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (!respOn) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (memQ.size() == 0) begin
                    checkOutput("unexpected_mem_req", {63'd0, mem_req}, 64'd0);
                    mem_ack = 1'b0;
                end else begin
                    m = memQ.pop_front();
                    checkOutput("mem_req_time", 64'($time), 64'(m.acceptTime + 5));
                    checkMemFields(m);
                    if (m.delay < 0) begin
                        mem_ack = 1'b0;
                        k = 1;
                        while (mem_req && k < 50) begin
                            @(negedge clk);
                            if (mem_req) k++;
                        end
                        checkOutput("timeout_cycles", 64'(k), 64'(TO));
                    end else begin
                        for (int i = 0; i < m.delay; i++) begin
                            mem_ack   = 1'b0;
                            mem_rdata = $urandom;
                            @(negedge clk);
                            checkMemFields(m);
                        end
                        mem_ack     = 1'b1;
                        mem_rdata   = m.rdata;
                        lastAckTime = $time;
                        @(negedge clk);
                        mem_ack   = 1'b0;
                        mem_rdata = $urandom;
                        checkOutput("mem_req_drop", {63'd0, mem_req}, 64'd0);
                    end
                end
            end else begin
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Response monitor: every response must match the oldest expectation
    // and arrive on the predicted cycle; outside a response the data and
    // fault outputs must read zero.
    initial begin
        expResp_t e;
        time want;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_resp", {63'd0, resp_valid}, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    if (e.timeout)      want = e.acceptTime + 5 + 10 * TO;
                    else if (e.memPath) want = lastAckTime + 10;
                    else                want = e.acceptTime + 5;
                    checkOutput("resp_rdata", {32'd0, resp_rdata}, {32'd0, e.rdata});
                    checkOutput("resp_fault", {62'd0, resp_fault}, {62'd0, e.fault});
                    checkOutput("resp_time", 64'($time), 64'(want));
                end
            end else begin
                checkOutput("idle_resp", {30'd0, resp_fault, resp_rdata}, 64'd0);
            end
        end
    end

    initial begin
        int n;
        int maxDelay;
        logic [31:0] addr;
`ifdef LSU_TIMEOUT_EN
        maxDelay = TO - 1;
`else
        maxDelay = 5;
`endif
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;

        #12;
        checkOutput("reset_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("reset_mem_req", {63'd0, mem_req}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a memory wait.
        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h0000_0100;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("pre_reset_mem_req", {63'd0, mem_req}, 64'd1);
        checkOutput("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_mem_req", {63'd0, mem_req}, 64'd0);
        checkOutput("async_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("async_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        respOn = 1'b1;

        // Directed cases.
        applyStimulus(1'b0, 3'd0, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0);
        applyStimulus(1'b0, 3'd4, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0);
        applyStimulus(1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, maxDelay);
        applyStimulus(1'b0, 3'd2, 32'h0000_3002, 32'd0, 32'd0, 0);
        applyStimulus(1'b1, 3'd3, 32'h0000_3000, 32'h5555_AAAA, 32'd0, 0);
        applyStimulus(1'b0, 3'd1, 32'h0000_4002, 32'd0, 32'h8001_7FFF, 1);
        applyStimulus(1'b0, 3'd5, 32'h0000_4002, 32'd0, 32'h8001_7FFF, 2);
        applyStimulus(1'b1, 3'd0, 32'h0000_5001, 32'h0000_00A5, 32'd0, 0);
        applyStimulus(1'b0, 3'd6, 32'h0000_5000, 32'd0, 32'd0, 0);
`ifdef LSU_TIMEOUT_EN
        applyStimulus(1'b0, 3'd2, 32'h0000_6000, 32'd0, 32'h1357_9BDF, -1);
        applyStimulus(1'b0, 3'd2, 32'h0000_6004, 32'd0, 32'h2468_ACE0, TO - 1);
`endif

        // Random traffic; the next request is usually presented while the
        // previous one is still in flight.
        for (int t = 0; t < 250; t++) begin
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                req_valid = 1'b0;
            end
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr,
                          $urandom, $urandom, $urandom_range(0, maxDelay));
        end
        @(negedge clk);
        req_valid = 1'b0;

        n = 0;
        while ((expQ.size() != 0 || memQ.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput("drain_resp", 64'(expQ.size()), 64'd0);
        checkOutput("drain_mem", 64'(memQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
